// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the ROM-loader byte-stream initiator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rom_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int HDR_BYTES  = 3;
  localparam int WORD_BYTES = 4;

  // Top nibble the memory block decodes as pak RAM for rpg accesses.
  localparam logic [3:0] PAK_BASE = 4'h8;

endpackage

// File: rtl/rom_loader_byte_packer.sv
// Little-endian byte assembler: collects last_idx+1 bytes into a 32-bit word.
// Latency: word_ready/word_dat are combinational on the accepting cycle (include current byte).
// Backpressure: none of its own; the caller gates byte_vld with its handshake.
module rom_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  input  logic [1:0]  last_idx,
  output logic [31:0] word_dat,
  output logic        word_ready
);

  logic [1:0]  cnt_q;
  logic [31:0] word_q;

  // Present the word including the byte being accepted, so the caller can act on the same edge.
  always_comb begin
    word_dat   = word_q;
    word_ready = 1'b0;
    if (byte_vld) begin
      word_dat[8*cnt_q +: 8] = byte_dat;
      word_ready             = (cnt_q == last_idx);
    end
  end

  // Byte lane counter and assembly register; wraps to lane 0 after the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (clear) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else if (byte_vld) begin
      word_q <= word_dat;
      cnt_q  <= word_ready ? 2'd0 : cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/rom_loader.sv
// Loads a length-prefixed little-endian byte stream into pak RAM through the rpg write port.
// Latency: 4th byte of a word accepted at edge t -> rpg_write high during cycle t+1.
// Backpressure: in_ready is low outside HDR/DATA (including every WRITE cycle); source holds the byte.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int          ADDR_W    = 23,
  parameter int unsigned MAX_WORDS = 8388608
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              rpg,
  output logic [ADDR_W-1:0] rpg_addr,
  output logic [31:0]       rpg_data,
  output logic              rpg_write,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       checksum
);

  state_t              state_q, state_d;
  logic                pk_clear;
  logic [1:0]          pk_last;
  logic                pk_vld;
  logic [31:0]         pk_word;
  logic                pk_ready;
  logic [23:0]         n_q;
  logic [23:0]         n_hdr;
  logic                hdr_bad;
  logic                is_last;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   rpg_addr_q;
  logic [31:0]         rpg_data_q;
  logic [31:0]         checksum_q;
  logic                err_q;

  assign pk_vld  = in_valid && in_ready;
  assign n_hdr   = pk_word[23:0];
  assign hdr_bad = 32'(n_hdr) > MAX_WORDS;
  assign is_last = (24'(idx_q) == (n_q - 24'd1));

  rom_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .byte_vld   (pk_vld),
    .byte_dat   (in_data),
    .last_idx   (pk_last),
    .word_dat   (pk_word),
    .word_ready (pk_ready)
  );

  // Next-state selection; abort out of any active state overrides everything else.
  always_comb begin
    state_d  = state_q;
    pk_clear = 1'b0;
    pk_last  = 2'(WORD_BYTES - 1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_HDR;
          pk_clear = 1'b1;
        end
      end
      ST_HDR: begin
        pk_last = 2'(HDR_BYTES - 1);
        if (pk_ready) begin
          if (n_hdr == 24'd0) state_d = ST_DONE;
          else if (hdr_bad)   state_d = ST_IDLE;
          else                state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (pk_ready) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = is_last ? ST_DONE : ST_DATA;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      pk_clear = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: header capture, word/address staging for the write cycle, checksum and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q        <= 24'd0;
      idx_q      <= '0;
      rpg_addr_q <= '0;
      rpg_data_q <= 32'd0;
      checksum_q <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        checksum_q <= 32'd0;
        err_q      <= 1'b0;
      end
      if ((state_q == ST_HDR) && pk_ready && !abort) begin
        n_q   <= n_hdr;
        idx_q <= '0;
        if (n_hdr != 24'd0 && hdr_bad) err_q <= 1'b1;
      end
      if ((state_q == ST_DATA) && pk_ready && !abort) begin
        rpg_data_q <= pk_word;
        rpg_addr_q <= idx_q;
      end
      // The strobe is already on the port this cycle, so the word counts as written.
      if (state_q == ST_WRITE) begin
        checksum_q <= checksum_q + rpg_data_q;
        idx_q      <= idx_q + 1'b1;
      end
    end
  end

  assign in_ready  = (state_q == ST_HDR) || (state_q == ST_DATA);
  assign rpg       = (state_q != ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rpg_write = (state_q == ST_WRITE);
  assign done      = (state_q == ST_DONE);
  assign rpg_addr  = rpg_addr_q;
  assign rpg_data  = rpg_data_q;
  assign checksum  = checksum_q;
  assign err       = err_q;

endmodule
